// File: rtl/pipe_mux_nto1.sv
// ============================================================================
// Module   : pipe_mux_nto1
// Brief    : N-to-1 word selector feeding a 2-entry valid/ready skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mux_nto1 #(
   parameter int SIZE     = 32,
   parameter int NUM      = 4,
   parameter int SEL_W    = 2,
   parameter int OOR_MODE = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM*SIZE-1:0] data_i,
   input  logic [SEL_W-1:0]    select_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic                flush_i,
   output logic [SIZE-1:0]     data_o,
   output logic                err_o,
   output logic                valid_o,
   input  logic                ready_i
);

   localparam logic [1:0]     S_EMPTY = 2'd0;
   localparam logic [1:0]     S_ONE   = 2'd1;
   localparam logic [1:0]     S_TWO   = 2'd2;
   localparam logic [SEL_W:0] C_NUM   = (SEL_W+1)'(NUM);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic            w_accept;
   logic            w_pop;
   logic            w_oor;
   logic [SIZE-1:0] w_sel_word;
   logic [SIZE-1:0] w_new_data;
   logic [SIZE-1:0] r_head_data;
   logic            r_head_err;
   logic [SIZE-1:0] r_skid_data;
   logic            r_skid_err;
   logic [SIZE-1:0] r_last_good;

   assign w_accept = valid_i & ready_o;
   assign w_pop    = valid_o & ready_i;
   assign w_oor    = ({1'b0, select_i} >= C_NUM);

   always_comb begin
      w_sel_word = '0;
      for (int k = 0; k < NUM; k++) begin
         if (select_i == SEL_W'(k)) begin
            w_sel_word = data_i[k*SIZE +: SIZE];
         end
      end
   end

   assign w_new_data = w_oor ? ((OOR_MODE != 0) ? r_last_good : '0) : w_sel_word;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush overrides any handshake in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
            S_ONE: begin
               if (w_accept && !w_pop) begin
                  w_state_nxt = S_TWO;
               end else if (!w_accept && w_pop) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO:   if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Output decode straight from the registered state
   always_comb begin
      ready_o = (r_state != S_TWO);
      valid_o = (r_state != S_EMPTY);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_head_data <= '0;
         r_head_err  <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_last_good <= '0;
      end else if (flush_i) begin
         r_head_err <= 1'b0;
      end else begin
         if (w_accept && !w_oor) begin
            r_last_good <= w_sel_word;
         end
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_head_data <= w_new_data;
                  r_head_err  <= w_oor;
               end
            end
            S_ONE: begin
               if (w_accept && w_pop) begin
                  r_head_data <= w_new_data;
                  r_head_err  <= w_oor;
               end else if (w_accept) begin
                  r_skid_data <= w_new_data;
                  r_skid_err  <= w_oor;
               end
            end
            S_TWO: begin
               if (w_pop) begin
                  r_head_data <= r_skid_data;
                  r_head_err  <= r_skid_err;
               end
            end
            default: ;
         endcase
      end
   end

   assign data_o = r_head_data;
   assign err_o  = r_head_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mux_nto1.sv
// ============================================================================
// Module   : tb_pipe_mux_nto1
// Brief    : Scenario bench for pipe_mux_nto1 with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mux_nto1;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] data4 = '0;
   logic [95:0]  data3;
   logic [1:0]   sel = '0;
   logic         valid = 1'b0;
   logic         flush = 1'b0;
   logic         ready_in = 1'b0;

   logic [31:0]  d4, d3a, d3b;
   logic         e4, e3a, e3b, v4, v3a, v3b, r4, r3a, r3b;

   int errors = 0;
   int checks = 0;

   assign data3 = data4[95:0];

   always #5 clk = ~clk;

   pipe_mux_nto1 #(.SIZE(32), .NUM(4), .SEL_W(2), .OOR_MODE(0)) u_dut4 (
      .clk_i(clk), .rst_i(rst_n), .data_i(data4), .select_i(sel), .valid_i(valid),
      .ready_o(r4), .flush_i(flush), .data_o(d4), .err_o(e4), .valid_o(v4), .ready_i(ready_in));

   pipe_mux_nto1 #(.SIZE(32), .NUM(3), .SEL_W(2), .OOR_MODE(0)) u_dut3a (
      .clk_i(clk), .rst_i(rst_n), .data_i(data3), .select_i(sel), .valid_i(valid),
      .ready_o(r3a), .flush_i(flush), .data_o(d3a), .err_o(e3a), .valid_o(v3a), .ready_i(ready_in));

   pipe_mux_nto1 #(.SIZE(32), .NUM(3), .SEL_W(2), .OOR_MODE(1)) u_dut3b (
      .clk_i(clk), .rst_i(rst_n), .data_i(data3), .select_i(sel), .valid_i(valid),
      .ready_o(r3b), .flush_i(flush), .data_o(d3b), .err_o(e3b), .valid_o(v3b), .ready_i(ready_in));

   // Reference model: a 2-deep FIFO of selected words per DUT
   ent_t        q4[$], q3a[$], q3b[$];
   ent_t        n4, n3a, n3b;
   logic [31:0] lg4, lg3;
   logic        m_acc, m_pop;

   function automatic ent_t mk(int num, int mode, logic [127:0] d, logic [1:0] s, logic [31:0] lg);
      ent_t r;
      if (int'(s) >= num) begin
         r.d = (mode != 0) ? lg : 32'h0;
         r.e = 1'b1;
      end else begin
         r.d = d[int'(s)*32 +: 32];
         r.e = 1'b0;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q4.delete(); q3a.delete(); q3b.delete();
         lg4 = '0; lg3 = '0;
      end else begin
         m_acc = valid && (q4.size() < 2);
         m_pop = ready_in && (q4.size() != 0);
         if (flush) begin
            q4.delete(); q3a.delete(); q3b.delete();
         end else begin
            n4  = mk(4, 0, data4, sel, lg4);
            n3a = mk(3, 0, {32'h0, data3}, sel, lg3);
            n3b = mk(3, 1, {32'h0, data3}, sel, lg3);
            if (m_acc && !n4.e)  lg4 = n4.d;
            if (m_acc && !n3a.e) lg3 = n3a.d;
            if (m_pop) begin
               void'(q4.pop_front()); void'(q3a.pop_front()); void'(q3b.pop_front());
            end
            if (m_acc) begin
               q4.push_back(n4); q3a.push_back(n3a); q3b.push_back(n3b);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b1; sel = 2'd1; data4 = {4{32'hDEAD_BEEF}}; ready_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", v4); end
      checks++; if (d4 !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", d4); end
      checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", e4); end
      valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", r4); end
   endtask

   task automatic test_basic();
      data4 = {32'h44, 32'h33, 32'h22, 32'h11}; sel = 2'd2; valid = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", v4); end
      checks++; if (d4 !== 32'h33) begin errors++; $display("FAIL basic_data got=%h exp=33", d4); end
      checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", e4); end
      @(negedge clk);
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", v4); end
   endtask

   task automatic test_backpressure();
      ready_in = 1'b0; valid = 1'b1; sel = 2'd0;
      @(negedge clk);
      sel = 2'd1;
      checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", r4); end
      @(negedge clk);
      sel = 2'd3;
      checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", r4); end
      checks++; if (d4 !== 32'h11) begin errors++; $display("FAIL bp_head got=%h exp=11", d4); end
      @(negedge clk);
      checks++; if (d4 !== 32'h11 || v4 !== 1'b1) begin
         errors++; $display("FAIL bp_hold got=%h/%b exp=11/1", d4, v4);
      end
      checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got=%b exp=0", r4); end
      valid = 1'b0; ready_in = 1'b1;
      @(negedge clk);
      checks++; if (d4 !== 32'h22 || v4 !== 1'b1) begin
         errors++; $display("FAIL bp_drain2 got=%h/%b exp=22/1", d4, v4);
      end
      @(negedge clk);
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0 (sel3 leaked)", v4); end
   endtask

   task automatic test_oor();
      data4 = {32'h44, 32'h33, 32'h22, 32'h11}; sel = 2'd1; valid = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      sel = 2'd3;
      checks++; if (d3a !== 32'h22 || e3a !== 1'b0) begin
         errors++; $display("FAIL oor_inrange got=%h/%b exp=22/0", d3a, e3a);
      end
      @(negedge clk);
      valid = 1'b0;
      checks++; if (d3a !== 32'h0 || e3a !== 1'b1) begin
         errors++; $display("FAIL oor_mode0 got=%h/%b exp=0/1", d3a, e3a);
      end
      checks++; if (d3b !== 32'h22 || e3b !== 1'b1) begin
         errors++; $display("FAIL oor_mode1 got=%h/%b exp=22/1", d3b, e3b);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      data4 = {32'h44, 32'h33, 32'h22, 32'h11}; ready_in = 1'b0; valid = 1'b1; sel = 2'd0;
      @(negedge clk);
      sel = 2'd1;
      @(negedge clk);
      flush = 1'b1; sel = 2'd2;
      @(negedge clk);
      flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
      checks++; if (v4 !== 1'b0 || r4 !== 1'b1) begin
         errors++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", v4, r4);
      end
      checks++; if (e4 !== 1'b0 || d4 !== 32'h11) begin
         errors++; $display("FAIL flush_data got=%h/%b exp=11/0", d4, e4);
      end
      @(negedge clk);
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL flush_leak got=%b exp=0", v4); end
      valid = 1'b1; sel = 2'd3;
      @(negedge clk);
      valid = 1'b0;
      checks++; if (d3b !== 32'h22 || e3b !== 1'b1) begin
         errors++; $display("FAIL flush_last_good got=%h/%b exp=22/1", d3b, e3b);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      data4 = {32'h44, 32'h33, 32'h22, 32'h11}; ready_in = 1'b0; valid = 1'b1; sel = 2'd2;
      @(negedge clk);
      sel = 2'd3;
      @(negedge clk);
      valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (v4 !== 1'b0 || d4 !== 32'h0 || e4 !== 1'b0) begin
         errors++; $display("FAIL midreset got=%b/%h/%b exp=0/0/0", v4, d4, e4);
      end
      @(negedge clk);
      rst_n = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL midreset_skid got=%b exp=0", v4); end
   endtask

   task automatic test_stream();
      logic [31:0] prev;
      prev = '0;
      ready_in = 1'b1; valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            checks++; if (v4 !== 1'b1 || d4 !== prev) begin
               errors++; $display("FAIL stream_%0d got=%h/%b exp=%h/1", i, d4, v4, prev);
            end
         end
         checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", i, r4); end
         data4 = {$urandom, $urandom, $urandom, $urandom};
         sel = 2'(i % 4);
         prev = data4[int'(sel)*32 +: 32];
         @(negedge clk);
      end
      valid = 1'b0;
      checks++; if (v4 !== 1'b1 || d4 !== prev) begin
         errors++; $display("FAIL stream_last got=%h/%b exp=%h/1", d4, v4, prev);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         checks++; if (v4 !== (q4.size() != 0) || r4 !== (q4.size() < 2)) begin
            errors++; $display("FAIL rand_flow_%0d got v=%b r=%b exp size=%0d", i, v4, r4, q4.size());
         end
         if (q4.size() != 0) begin
            checks++; if (d4 !== q4[0].d || e4 !== q4[0].e) begin
               errors++; $display("FAIL rand_d4_%0d got=%h/%b exp=%h/%b", i, d4, e4, q4[0].d, q4[0].e);
            end
            checks++; if (d3a !== q3a[0].d || e3a !== q3a[0].e) begin
               errors++; $display("FAIL rand_d3a_%0d got=%h/%b exp=%h/%b", i, d3a, e3a, q3a[0].d, q3a[0].e);
            end
            checks++; if (d3b !== q3b[0].d || e3b !== q3b[0].e) begin
               errors++; $display("FAIL rand_d3b_%0d got=%h/%b exp=%h/%b", i, d3b, e3b, q3b[0].d, q3b[0].e);
            end
         end
         data4    = {$urandom, $urandom, $urandom, $urandom};
         sel      = 2'($urandom_range(0, 3));
         valid    = ($urandom_range(0, 3) != 0);
         ready_in = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_oor();
      test_flush();
      test_reset_mid();
      test_stream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
